apb_rr_master: RTL and testbench

Multi-requester APB master. It round-robin arbitrates N internal request ports and sequences the shared APB bus through IDLE/SETUP/ACCESS. Each transfer's read data and error status are returned to the originating requester. It sits between on-chip register clients (DMA, debug, CPU shim) and the APB bus monitored by the protocol assertion interface, so its output must satisfy those checks by construction.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_rr_arbiter.sv | 42 ++++
 rtl/apb_rr_master.sv | 174 +++++++++++++++++
 tb/tb_apb_rr_master.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the round-robin APB master and its arbiter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned PROT_W      = 3;
    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin one-hot arbiter: search starts one past the last grant and wraps.
module apb_rr_arbiter #(
    parameter int unsigned  NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   grant_idx_c
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;
    logic             found;

    // First requester at or after ptr+1 (modulo NUM_REQ) wins.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        cand        = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                grant_c[cand]  = 1'b1;
                grant_idx_c    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else if (accept_i) begin
            ptr_q <= grant_idx_c;
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Multi-requester APB master: arbitrates requesters round-robin and runs IDLE/SETUP/ACCESS.
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int unsigned  NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned  ADDR_W  = DEF_ADDR_W,
    parameter int unsigned  DATA_W  = DEF_DATA_W,
    parameter int unsigned  TIMEOUT = DEF_TIMEOUT,
    localparam int unsigned STRB_W  = DATA_W / 8
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0]   req_strb,
    input  logic [NUM_REQ*PROT_W-1:0]   req_prot,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        rsp_timeout,
    output logic                        PSEL,
    output logic                        PENABLE,
    output logic [ADDR_W-1:0]           PADDR,
    output logic                        PWRITE,
    output logic [DATA_W-1:0]           PWDATA,
    output logic [STRB_W-1:0]           PSTRB,
    output logic [PROT_W-1:0]           PPROT,
    input  logic [DATA_W-1:0]           PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        logic [PROT_W-1:0] prot;
    } apb_cmd_t;

    apb_state_e         state_q, state_d;
    apb_cmd_t           cmd_q, cmd_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_timeout_q, rsp_timeout_d;

    logic [NUM_REQ-1:0] grant_c;
    logic [IDX_W-1:0]   grant_idx_c;
    logic               accept_c;

    assign accept_c  = (state_q == IDLE) && (|req_valid);
    assign req_ready = (state_q == IDLE) ? grant_c : '0;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (PCLK),
        .rst_n       (PRESETn),
        .req_i       (req_valid),
        .accept_i    (accept_c),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    // Next-state and registered-output logic; bus fields hold their value outside a transfer.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        gidx_d        = gidx_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = '0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    cmd_d.addr  = req_addr[grant_idx_c*ADDR_W +: ADDR_W];
                    cmd_d.write = req_write[grant_idx_c];
                    cmd_d.wdata = req_wdata[grant_idx_c*DATA_W +: DATA_W];
                    cmd_d.strb  = req_write[grant_idx_c] ?
                                  req_strb[grant_idx_c*STRB_W +: STRB_W] : '0;
                    cmd_d.prot  = req_prot[grant_idx_c*PROT_W +: PROT_W];
                    gidx_d      = grant_idx_c;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d[gidx_q] = 1'b1;
                    rsp_err_d           = PSLVERR;
                    rsp_rdata_d         = cmd_q.write ? '0 : PRDATA;
                    psel_d              = 1'b0;
                    penable_d           = 1'b0;
                    state_d             = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_valid_d[gidx_q] = 1'b1;
                    rsp_err_d           = 1'b1;
                    rsp_timeout_d       = 1'b1;
                    psel_d              = 1'b0;
                    penable_d           = 1'b0;
                    state_d             = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            gidx_q        <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            gidx_q        <= gidx_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PADDR       = cmd_q.addr;
    assign PWRITE      = cmd_q.write;
    assign PWDATA      = cmd_q.wdata;
    assign PSTRB       = cmd_q.strb;
    assign PPROT       = cmd_q.prot;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed vector table, corner sequences and a randomized run vs. a timeline model.
module tb_apb_rr_master;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic             PCLK = 1'b0;
    logic             PRESETn = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR-1:0]    req_write = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR*SW-1:0] req_strb = '0;
    logic [NR*3-1:0]  req_prot = '0;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err, rsp_timeout;
    logic             PSEL, PENABLE, PWRITE;
    logic [AW-1:0]    PADDR;
    logic [DW-1:0]    PWDATA;
    logic [SW-1:0]    PSTRB;
    logic [2:0]       PPROT;
    logic [DW-1:0]    PRDATA = '0;
    logic             PREADY = 1'b0;
    logic             PSLVERR = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_rr_master #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // A transfer plus how the slave will answer it.
    typedef struct {
        int          rid;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          wt;
        logic        serr;
        logic        hang;
        logic [31:0] sdata;
    } txn_t;

    typedef struct {
        txn_t        t;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
        int          e_lat;
    } vec_t;

    txn_t pend [NR][512];
    int   head [NR];
    int   tail [NR];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   drop_pct = 0;

    // Reference model: last-granted pointer and position in the current transfer's timeline.
    int   m_ptr;
    bit   m_busy;
    int   m_k;
    txn_t m_cur;
    int   grants[$];

    int          obs_acc, obs_rsp;
    logic [31:0] obs_rdata;
    logic        obs_err, obs_to;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic txn_t zero_txn();
        txn_t t;
        t.rid = 0; t.addr = '0; t.wr = 1'b0; t.wdata = '0; t.strb = '0; t.prot = '0;
        t.wt = 0; t.serr = 1'b0; t.hang = 1'b0; t.sdata = '0;
        return t;
    endfunction

    function automatic int n_acc(input txn_t t);
        return t.hang ? TO : t.wt + 1;
    endfunction

    function automatic logic [NR-1:0] rr_pick(input logic [NR-1:0] v, input int ptr);
        for (int off = 1; off <= NR; off++) begin
            int c = (ptr + off) % NR;
            if (v[c]) return NR'(1) << c;
        end
        return '0;
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < NR; i++) if (head[i] < tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic vec_t mk(input int rid, input logic [31:0] addr, input logic wr,
                                input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                                input int wt, input logic se, input logic hg, input logic [31:0] sd,
                                input logic [31:0] er, input logic ee, input logic eto, input int lat);
        vec_t v;
        v.t.rid = rid; v.t.addr = addr; v.t.wr = wr; v.t.wdata = wd; v.t.strb = st;
        v.t.prot = pr; v.t.wt = wt; v.t.serr = se; v.t.hang = hg; v.t.sdata = sd;
        v.e_rdata = er; v.e_err = ee; v.e_to = eto; v.e_lat = lat;
        return v;
    endfunction

    task automatic enqueue(input txn_t t);
        pend[t.rid][tail[t.rid]] = t;
        tail[t.rid]++;
    endtask

    task automatic model_reset();
        m_ptr  = NR - 1;
        m_busy = 1'b0;
        m_k    = 0;
        m_cur  = zero_txn();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (head[i] < tail[i] && $urandom_range(0, 99) >= drop_pct) begin
                txn_t t = pend[i][head[i]];
                req_valid[i]           = 1'b1;
                req_addr[i*AW +: AW]   = t.addr;
                req_write[i]           = t.wr;
                req_wdata[i*DW +: DW]  = t.wdata;
                req_strb[i*SW +: SW]   = t.strb;
                req_prot[i*3 +: 3]     = t.prot;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    // One clock: drive at posedge+1, check and play the slave at negedge, then advance the model.
    task automatic step();
        int            n;
        bit            rsp_now, idle_now, exp_psel, exp_pen;
        logic [NR-1:0] exp_ready, exp_rsp;
        @(posedge PCLK); #1;
        drive_inputs();
        @(negedge PCLK);
        cyc++;
        n         = n_acc(m_cur);
        rsp_now   = m_busy && (m_k == 2 + n);
        idle_now  = !m_busy || rsp_now;
        exp_psel  = m_busy && m_k >= 1 && m_k <= 1 + n;
        exp_pen   = m_busy && m_k >= 2 && m_k <= 1 + n;
        exp_ready = idle_now ? rr_pick(req_valid, m_ptr) : '0;
        exp_rsp   = rsp_now ? (NR'(1) << m_cur.rid) : '0;

        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("PSEL", 64'(PSEL), 64'(exp_psel));
        chk("PENABLE", 64'(PENABLE), 64'(exp_pen));
        chk("PADDR", 64'(PADDR), 64'(m_cur.addr));
        chk("PWRITE", 64'(PWRITE), 64'(m_cur.wr));
        chk("PWDATA", 64'(PWDATA), 64'(m_cur.wdata));
        chk("PSTRB", 64'(PSTRB), 64'(m_cur.wr ? m_cur.strb : 4'h0));
        chk("PPROT", 64'(PPROT), 64'(m_cur.prot));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        if (rsp_now) begin
            chk("rsp_err", 64'(rsp_err), 64'(m_cur.hang | m_cur.serr));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(m_cur.hang));
            if (!m_cur.hang) chk("rsp_rdata", 64'(rsp_rdata), 64'(m_cur.wr ? 32'h0 : m_cur.sdata));
        end

        if ((req_valid & req_ready) != '0) obs_acc = cyc;
        if (rsp_valid != '0) begin
            obs_rsp = cyc; obs_rdata = rsp_rdata; obs_err = rsp_err; obs_to = rsp_timeout;
        end

        if (exp_pen) begin
            PREADY  = !m_cur.hang && (m_k - 2 == m_cur.wt);
            PRDATA  = m_cur.sdata;
            PSLVERR = m_cur.serr;
        end else begin
            PREADY  = 1'b0;
            PRDATA  = $urandom();
            PSLVERR = 1'($urandom_range(0, 1));
        end

        if (m_busy) begin
            if (rsp_now) m_busy = 1'b0;
            else m_k++;
        end
        if (exp_ready != '0) begin
            int rid = 0;
            for (int i = 0; i < NR; i++) if (exp_ready[i]) rid = i;
            m_cur  = pend[rid][head[rid]];
            head[rid]++;
            m_ptr  = rid;
            m_busy = 1'b1;
            m_k    = 1;
            grants.push_back(rid);
        end
    endtask

    task automatic drain(input int budget, input string tag);
        int c = 0;
        while ((m_busy || any_pending()) && c < budget) begin
            step();
            c++;
        end
        n_tests++;
        if (m_busy || any_pending()) begin
            n_fail++;
            $display("FAIL %s drain: still busy after %0d cycles, required idle", tag, c);
        end
    endtask

    // Asynchronous assert between edges, release at a falling edge.
    task automatic apply_reset(input bit check_now);
        #2;
        PRESETn   = 1'b0;
        req_valid = '0;
        PREADY    = 1'b0;
        #1;
        if (check_now) begin
            chk("rst PSEL", 64'(PSEL), 64'(0));
            chk("rst PENABLE", 64'(PENABLE), 64'(0));
            chk("rst rsp_valid", 64'(rsp_valid), 64'(0));
        end
        model_reset();
        repeat (2) begin
            @(posedge PCLK); #1;
            if (check_now) chk("rst no rsp", 64'(rsp_valid), 64'(0));
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin head[i] = 0; tail[i] = 0; end
        model_reset();
        vecs[0] = mk(0, 32'h1000, 1'b1, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 1'b0, 32'hAAAAAAAA,
                     32'h0, 1'b0, 1'b0, 3);
        vecs[1] = mk(1, 32'h2004, 1'b0, 32'h0, 4'h0, 3'd2, 3, 1'b0, 1'b0, 32'h12345678,
                     32'h12345678, 1'b0, 1'b0, 6);
        vecs[2] = mk(2, 32'h3008, 1'b1, 32'hCAFEF00D, 4'h3, 3'd1, 1, 1'b1, 1'b0, 32'h0,
                     32'h0, 1'b1, 1'b0, 4);
        vecs[3] = mk(3, 32'h400C, 1'b0, 32'h11111111, 4'hF, 3'd5, 0, 1'b0, 1'b0, 32'h0BADF00D,
                     32'h0BADF00D, 1'b0, 1'b0, 3);
        vecs[4] = mk(1, 32'h5010, 1'b0, 32'h0, 4'h0, 3'd3, 0, 1'b0, 1'b1, 32'h0,
                     32'h0, 1'b1, 1'b1, 2 + TO);
        vecs[5] = mk(0, 32'h6014, 1'b1, 32'h01020304, 4'hA, 3'd7, TO - 1, 1'b0, 1'b0, 32'h0,
                     32'h0, 1'b0, 1'b0, 2 + TO);
        vecs[6] = mk(2, 32'h7018, 1'b0, 32'h0, 4'h0, 3'd4, 2, 1'b1, 1'b0, 32'h55AA55AA,
                     32'h55AA55AA, 1'b1, 1'b0, 5);

        // Reset values
        repeat (2) @(negedge PCLK);
        chk("reset PSEL", 64'(PSEL), 64'(0));
        chk("reset PENABLE", 64'(PENABLE), 64'(0));
        chk("reset PADDR", 64'(PADDR), 64'(0));
        chk("reset PWRITE", 64'(PWRITE), 64'(0));
        chk("reset PWDATA", 64'(PWDATA), 64'(0));
        chk("reset PSTRB", 64'(PSTRB), 64'(0));
        chk("reset PPROT", 64'(PPROT), 64'(0));
        chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset rsp_err", 64'(rsp_err), 64'(0));
        chk("reset rsp_timeout", 64'(rsp_timeout), 64'(0));
        chk("reset rsp_rdata", 64'(rsp_rdata), 64'(0));
        PRESETn = 1'b1;

        // Directed vector table, one transfer at a time
        drop_pct = 0;
        for (int v = 0; v < 7; v++) begin
            enqueue(vecs[v].t);
            obs_acc = -1;
            obs_rsp = -1;
            drain(64, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d latency", v), 64'(obs_rsp - obs_acc), 64'(vecs[v].e_lat));
            chk($sformatf("vec%0d rsp_err", v), 64'(obs_err), 64'(vecs[v].e_err));
            chk($sformatf("vec%0d rsp_timeout", v), 64'(obs_to), 64'(vecs[v].e_to));
            if (!vecs[v].e_to)
                chk($sformatf("vec%0d rsp_rdata", v), 64'(obs_rdata), 64'(vecs[v].e_rdata));
        end

        // Fairness: everyone requests continuously from a fresh pointer
        apply_reset(1'b0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) begin
                txn_t t = zero_txn();
                t.rid = i; t.addr = 32'h100 * (i + 1) + 32'(r); t.wr = 1'(r); t.wdata = $urandom();
                t.strb = 4'hF; t.sdata = $urandom();
                enqueue(t);
            end
        grants.delete();
        drain(200, "fair");
        chk("fair count", 64'(grants.size()), 64'(8));
        for (int g = 0; g < 8 && g < grants.size(); g++)
            chk($sformatf("fair grant%0d", g), 64'(grants[g]), 64'(g % NR));

        // Reset in the middle of a stalled ACCESS
        begin
            txn_t t = zero_txn();
            int   c = 0;
            t.rid = 2; t.addr = 32'h9000; t.hang = 1'b1;
            enqueue(t);
            while (PENABLE !== 1'b1 && c < 10) begin step(); c++; end
            chk("midrst reached ACCESS", 64'(PENABLE), 64'(1));
            repeat (3) step();
            apply_reset(1'b1);
            t = zero_txn(); t.rid = 3; t.addr = 32'hA000; enqueue(t);
            t = zero_txn(); t.rid = 0; t.addr = 32'hB000; enqueue(t);
            grants.delete();
            drain(40, "midrst");
            chk("midrst grant count", 64'(grants.size()), 64'(2));
            if (grants.size() == 2) begin
                chk("midrst first grant", 64'(grants[0]), 64'(0));
                chk("midrst second grant", 64'(grants[1]), 64'(3));
            end
        end

        // Randomized traffic with dropping requests and varied slave behaviour
        drop_pct = 25;
        for (int n = 0; n < 300; n++) begin
            txn_t t;
            t.rid   = int'($urandom_range(0, NR - 1));
            t.addr  = $urandom();
            t.wr    = 1'($urandom_range(0, 1));
            t.wdata = $urandom();
            t.strb  = 4'($urandom_range(0, 15));
            t.prot  = 3'($urandom_range(0, 7));
            t.wt    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, TO - 1))
                                                  : int'($urandom_range(0, 2));
            t.serr  = ($urandom_range(0, 7) == 0);
            t.hang  = ($urandom_range(0, 19) == 0);
            t.sdata = $urandom();
            enqueue(t);
        end
        drain(20000, "random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
